// File: rtl/countdown_pkg.sv
// Shared types, limits and helpers for the MM:SS countdown timer.
package countdown_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t DIGIT_MAX    = 4'd9;

    // Clamp an out-of-range BCD digit to the largest legal value for its position.
    function automatic bcd_t sat_digit(input bcd_t val, input bcd_t max);
        return (val > max) ? max : val;
    endfunction

    // Digit positions: 0 = sec ones, 1 = sec tens, 2 = min ones, 3 = min tens.
    function automatic bcd_t digit_limit(input int unsigned idx);
        return (idx == 1) ? SEC_TENS_MAX : DIGIT_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of the countdown chain: loads a value or decrements with wrap-to-MAX borrow.
module bcd_digit_down
    import countdown_pkg::*;
#(
    parameter bcd_t MAX = DIGIT_MAX
) (
    input  logic clk,
    input  logic reset_n,
    input  logic dec_en,
    input  logic load_en,
    input  bcd_t load_val,
    output bcd_t digit,
    output logic borrow_out
);

    bcd_t digit_q;
    bcd_t digit_d;

    // Load has priority over decrement; a zero digit wraps to MAX and borrows upward.
    always_comb begin
        digit_d = digit_q;
        if (load_en) begin
            digit_d = load_val;
        end else if (dec_en) begin
            digit_d = (digit_q == 4'd0) ? MAX : digit_q - 4'd1;
        end
    end

    // Digit register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit      = digit_q;
    assign borrow_out = dec_en && (digit_q == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer: FSM, one-second prescaler, preset saturation and digit chain.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int unsigned TICK_COUNT = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_stop,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] pre_min_tens,
    input  logic [3:0] pre_min_ones,
    input  logic [3:0] pre_sec_tens,
    input  logic [3:0] pre_sec_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       expired,
    output logic       alarm
);

    localparam int PRESC_W = 26;
    localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK_COUNT - 1);

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               running_q, running_d;
    logic               expired_q, expired_d;
    logic               alarm_q, alarm_d;

    bcd_t       digit    [4];
    bcd_t       load_val [4];
    bcd_t       preset   [4];
    logic       dig_load;
    logic       dec_tick;
    logic [3:0] dec_vec;
    logic [3:0] borrow;
    logic       borrow_unused;
    logic       time_zero;
    logic       last_second;

    assign preset[0] = pre_sec_ones;
    assign preset[1] = pre_sec_tens;
    assign preset[2] = pre_min_ones;
    assign preset[3] = pre_min_tens;

    assign time_zero   = (digit[3] == 4'd0) && (digit[2] == 4'd0) &&
                         (digit[1] == 4'd0) && (digit[0] == 4'd0);
    assign last_second = (digit[3] == 4'd0) && (digit[2] == 4'd0) &&
                         (digit[1] == 4'd0) && (digit[0] == 4'd1);

    // The tick enters at sec ones; each borrow feeds the next digit up.
    assign dec_vec       = {borrow[2:0], dec_tick};
    assign borrow_unused = borrow[3];

    // Next-state, prescaler and digit control in priority order clr > load > start_stop > tick.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        expired_d = expired_q;
        alarm_d   = 1'b0;
        dig_load  = 1'b0;
        dec_tick  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load_val[i] = sat_digit(preset[i], digit_limit(i));
        end

        if (clr) begin
            dig_load  = 1'b1;
            for (int i = 0; i < 4; i++) begin
                load_val[i] = 4'd0;
            end
            presc_d   = '0;
            state_d   = IDLE;
            expired_d = 1'b0;
        end else if (load) begin
            dig_load  = 1'b1;
            presc_d   = '0;
            state_d   = IDLE;
            expired_d = 1'b0;
        end else if (start_stop) begin
            // The prescaler is left untouched so a resume continues the partial second.
            case (state_q)
                IDLE:    if (!time_zero) state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = state_q;
            endcase
        end else if (state_q == RUN) begin
            if (presc_q == TICK_LAST) begin
                presc_d  = '0;
                dec_tick = 1'b1;
                if (last_second) begin
                    state_d   = DONE;
                    expired_d = 1'b1;
                    alarm_d   = 1'b1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        running_d = (state_d == RUN);
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            expired_q <= expired_d;
            alarm_q   <= alarm_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            bcd_digit_down #(
                .MAX (digit_limit(gi))
            ) u_digit (
                .clk        (clk),
                .reset_n    (reset_n),
                .dec_en     (dec_vec[gi]),
                .load_en    (dig_load),
                .load_val   (load_val[gi]),
                .digit      (digit[gi]),
                .borrow_out (borrow[gi])
            );
        end
    endgenerate

    assign sec_ones = digit[0];
    assign sec_tens = digit[1];
    assign min_ones = digit[2];
    assign min_tens = digit[3];
    assign running  = running_q;
    assign expired  = expired_q;
    assign alarm    = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer against a seconds-based reference model.
module tb_countdown_timer;

    localparam int T = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_stop = 1'b0, clr = 1'b0, load = 1'b0;
    logic [3:0] pre_min_tens = 4'd0, pre_min_ones = 4'd0, pre_sec_tens = 4'd0, pre_sec_ones = 4'd0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, expired, alarm;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining seconds, cycles into the current second, mode, alarm.
    int m_secs = 0, m_phase = 0, m_mode = M_IDLE;
    bit m_alarm = 1'b0;

    countdown_timer #(.TICK_COUNT(T)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_stop   (start_stop),
        .clr          (clr),
        .load         (load),
        .pre_min_tens (pre_min_tens),
        .pre_min_ones (pre_min_ones),
        .pre_sec_tens (pre_sec_tens),
        .pre_sec_ones (pre_sec_ones),
        .min_tens     (min_tens),
        .min_ones     (min_ones),
        .sec_tens     (sec_tens),
        .sec_ones     (sec_ones),
        .running      (running),
        .expired      (expired),
        .alarm        (alarm)
    );

    always #5 clk = ~clk;

    logic [15:0] dut_time;
    logic [18:0] dut_vec;
    assign dut_time = {min_tens, min_ones, sec_tens, sec_ones};
    assign dut_vec  = {dut_time, running, expired, alarm};

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [15:0] secs_to_bcd(input int s);
        return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    function automatic logic [18:0] model_vec();
        return {secs_to_bcd(m_secs), (m_mode == M_RUN), (m_mode == M_DONE), m_alarm};
    endfunction

    // Advance the model by one clock edge with the inputs sampled at that edge.
    task automatic model_step(input bit rn, input bit ss, input bit c, input bit l, input logic [15:0] pre);
        m_alarm = 1'b0;
        if (!rn) begin
            m_secs = 0; m_phase = 0; m_mode = M_IDLE;
        end else if (c) begin
            m_secs = 0; m_phase = 0; m_mode = M_IDLE;
        end else if (l) begin
            m_secs = imin(int'(pre[15:12]), 9) * 600 + imin(int'(pre[11:8]), 9) * 60 +
                     imin(int'(pre[7:4]), 5) * 10 + imin(int'(pre[3:0]), 9);
            m_phase = 0; m_mode = M_IDLE;
        end else if (ss) begin
            if (m_mode == M_IDLE && m_secs != 0) m_mode = M_RUN;
            else if (m_mode == M_RUN)            m_mode = M_PAUSE;
            else if (m_mode == M_PAUSE)          m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            m_phase++;
            if (m_phase == T) begin
                m_phase = 0;
                m_secs--;
                if (m_secs == 0) begin
                    m_mode  = M_DONE;
                    m_alarm = 1'b1;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model, then release the pulses.
    task automatic cyc(input bit rn, input bit ss, input bit c, input bit l, input logic [15:0] pre);
        reset_n = rn; start_stop = ss; clr = c; load = l;
        {pre_min_tens, pre_min_ones, pre_sec_tens, pre_sec_ones} = pre;
        @(posedge clk);
        model_step(rn, ss, c, l, pre);
        #1;
        reset_n = 1'b1; start_stop = 1'b0; clr = 1'b0; load = 1'b0;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 16'h0000);
    endtask

    task automatic test_reset();
        cyc(0, 0, 0, 0, 16'h0000);
        cyc(0, 0, 0, 0, 16'h0000);
        checks++;
        if (dut_vec !== 19'd0) begin
            errors++; $display("FAIL reset_state got=%h want=%h", dut_vec, 19'd0);
        end
        cyc(1, 1, 0, 0, 16'h0000);
        checks++;
        if (running !== 1'b0 || dut_vec !== model_vec()) begin
            errors++; $display("FAIL start_at_zero running=%b vec=%h want_vec=%h", running, dut_vec, model_vec());
        end
        $display("test_reset done: time=%h running=%b", dut_time, running);
    endtask

    task automatic test_expire();
        cyc(1, 0, 0, 1, 16'h0003);
        cyc(1, 1, 0, 0, 16'h0000);
        checks++;
        if (running !== 1'b1) begin
            errors++; $display("FAIL expire_start running=%b want=1", running);
        end
        for (int c = 1; c <= 13; c++) begin
            idle_n(1);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; $display("FAIL expire_cycle%0d got=%h want=%h", c, dut_vec, model_vec());
            end
            if (c == 4 || c == 8 || c == 12) begin
                checks++;
                if (dut_time !== secs_to_bcd(3 - c / 4)) begin
                    errors++; $display("FAIL expire_digits_c%0d got=%h want=%h", c, dut_time, secs_to_bcd(3 - c / 4));
                end
            end
        end
        checks++;
        if (alarm !== 1'b0 || expired !== 1'b1 || running !== 1'b0) begin
            errors++; $display("FAIL expire_after alarm=%b expired=%b running=%b want 0/1/0", alarm, expired, running);
        end
        cyc(1, 1, 0, 0, 16'h0000);
        idle_n(2);
        checks++;
        if (running !== 1'b0 || expired !== 1'b1 || dut_time !== 16'h0000) begin
            errors++; $display("FAIL done_ignores_start running=%b expired=%b time=%h", running, expired, dut_time);
        end
        $display("test_expire done: time=%h expired=%b", dut_time, expired);
    endtask

    task automatic test_borrow();
        cyc(1, 0, 0, 1, 16'h1000);
        cyc(1, 1, 0, 0, 16'h0000);
        idle_n(T);
        checks++;
        if (dut_time !== 16'h0959 || dut_vec !== model_vec()) begin
            errors++; $display("FAIL borrow_1000 got=%h want=%h", dut_time, 16'h0959);
        end
        cyc(1, 0, 0, 1, 16'h0100);
        cyc(1, 1, 0, 0, 16'h0000);
        idle_n(T);
        checks++;
        if (dut_time !== 16'h0059 || dut_vec !== model_vec()) begin
            errors++; $display("FAIL borrow_0100 got=%h want=%h", dut_time, 16'h0059);
        end
        $display("test_borrow done: time=%h", dut_time);
    endtask

    task automatic test_pause();
        cyc(1, 0, 0, 1, 16'h0005);
        cyc(1, 1, 0, 0, 16'h0000);
        idle_n(2);
        cyc(1, 1, 0, 0, 16'h0000);
        idle_n(20);
        checks++;
        if (dut_time !== 16'h0005 || running !== 1'b0 || dut_vec !== model_vec()) begin
            errors++; $display("FAIL pause_hold got=%h running=%b want=0005/0", dut_time, running);
        end
        cyc(1, 1, 0, 0, 16'h0000);
        idle_n(1);
        checks++;
        if (dut_time !== 16'h0005) begin
            errors++; $display("FAIL resume_early got=%h want=0005", dut_time);
        end
        idle_n(1);
        checks++;
        if (dut_time !== 16'h0004 || dut_vec !== model_vec()) begin
            errors++; $display("FAIL resume_partial got=%h want=0004", dut_time);
        end
        $display("test_pause done: time=%h", dut_time);
    endtask

    task automatic test_saturate();
        cyc(1, 0, 0, 1, 16'h1C73);
        checks++;
        if (dut_time !== 16'h1953 || dut_vec !== model_vec()) begin
            errors++; $display("FAIL saturate got=%h want=1953", dut_time);
        end
        cyc(1, 0, 0, 1, 16'hFFFF);
        checks++;
        if (dut_time !== 16'h9959) begin
            errors++; $display("FAIL saturate_all got=%h want=9959", dut_time);
        end
        cyc(1, 1, 0, 0, 16'h0000);
        cyc(1, 0, 1, 1, 16'h0042);
        checks++;
        if (dut_vec !== 19'd0 || dut_vec !== model_vec()) begin
            errors++; $display("FAIL clr_over_load got=%h want=%h", dut_vec, 19'd0);
        end
        $display("test_saturate done: time=%h", dut_time);
    endtask

    task automatic test_reset_midrun();
        cyc(1, 0, 0, 1, 16'h0003);
        cyc(1, 1, 0, 0, 16'h0000);
        idle_n(T);
        checks++;
        if (dut_time !== 16'h0002) begin
            errors++; $display("FAIL midrun_pre got=%h want=0002", dut_time);
        end
        cyc(0, 0, 0, 0, 16'h0000);
        checks++;
        if (dut_vec !== 19'd0) begin
            errors++; $display("FAIL midrun_reset got=%h want=%h", dut_vec, 19'd0);
        end
        $display("test_reset_midrun done: time=%h", dut_time);
    endtask

    task automatic test_stop_on_tick();
        cyc(1, 0, 0, 1, 16'h0003);
        cyc(1, 1, 0, 0, 16'h0000);
        idle_n(T - 1);
        cyc(1, 1, 0, 0, 16'h0000);
        checks++;
        if (dut_time !== 16'h0003 || running !== 1'b0 || dut_vec !== model_vec()) begin
            errors++; $display("FAIL stop_on_tick got=%h running=%b want=0003/0", dut_time, running);
        end
        cyc(1, 1, 0, 0, 16'h0000);
        idle_n(1);
        checks++;
        if (dut_time !== 16'h0002 || dut_vec !== model_vec()) begin
            errors++; $display("FAIL tick_after_resume got=%h want=0002", dut_time);
        end
        $display("test_stop_on_tick done: time=%h", dut_time);
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 600; i++) begin
            bit rn, ss, c, l;
            logic [15:0] pre;
            rn = ($urandom_range(0, 199) != 0);
            ss = ($urandom_range(0, 15) == 0);
            c  = ($urandom_range(0, 79) == 0);
            l  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) pre = 16'($urandom);
            else pre = {8'h00, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
            cyc(rn, ss, c, l, pre);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; bad++;
                if (bad <= 10) $display("FAIL random_cycle%0d got=%h want=%h", i, dut_vec, model_vec());
            end
        end
        $display("test_random done: 600 cycles, %0d mismatching", bad);
    endtask

    initial begin
        test_reset();
        test_expire();
        test_borrow();
        test_pause();
        test_saturate();
        test_reset_midrun();
        test_stop_on_tick();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- MM:SS BCD countdown timer. Pairs with the up-counting stopwatch to form the panel timer subsystem.
- Software or panel logic loads a preset. The block decrements once per second-tick to 00:00, then raises an alarm.
- Outputs drive the same 4-digit display path as the stopwatch.

Parameters:
- TICK_COUNT, default 10: clk cycles per one-second tick while running. Use 50_000_000 for 50 MHz silicon; use a small value in simulation. Legal range 2..2^26-1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  synchronous reset, active-low.
- start_stop  input  1  one-cycle pulse: start, pause or resume.
- clr  input  1  one-cycle pulse: zero time, return to IDLE.
- load  input  1  one-cycle pulse: capture the preset digits.
- pre_min_tens  input  4  preset minutes tens, BCD.
- pre_min_ones  input  4  preset minutes ones, BCD.
- pre_sec_tens  input  4  preset seconds tens, BCD.
- pre_sec_ones  input  4  preset seconds ones, BCD.
- min_tens  output  4  current minutes tens.
- min_ones  output  4  current minutes ones.
- sec_tens  output  4  current seconds tens.
- sec_ones  output  4  current seconds ones.
- running  output  1  high in RUN state.
- expired  output  1  sticky high in DONE state.
- alarm  output  1  one-cycle pulse on reaching 00:00.

Behaviour:
- Reset: reset_n sampled low at a clk edge sets the following. All four digits 0, prescaler 0, state IDLE, running 0, expired 0, alarm 0.
- States:
  - IDLE: time loaded or zero, not counting.
  - RUN: counting.
  - PAUSE: frozen mid-count.
  - DONE: reached 00:00.
- Priority per cycle: reset_n > clr > load > start_stop > tick.
- clr, in any state: digits 0, prescaler 0, go to IDLE, expired 0.
- load, in any state:
  - Digits take the preset values, registered with 1-cycle latency.
  - Out-of-range preset digits saturate: sec_tens >5 becomes 5; any other digit >9 becomes 9.
  - Prescaler 0, go to IDLE, expired 0.
- start_stop transitions:
  - IDLE: go to RUN if the time is not 00:00; otherwise ignored.
  - RUN: go to PAUSE.
  - PAUSE: go to RUN.
  - DONE: ignored.
- Prescaler:
  - Increments each cycle only in RUN.
  - Holds its value in PAUSE, so resume continues the partial second.
  - When it equals TICK_COUNT-1, it wraps to 0 and generates a tick. Tick period is exactly TICK_COUNT cycles.
- The first decrement occurs TICK_COUNT cycles after the start_stop edge that enters RUN.
- start_stop and a tick in the same RUN cycle: start_stop wins. No decrement that cycle, prescaler holds, go to PAUSE.
- Decrement on tick, with BCD borrow chain:
  - sec_ones: value >0 decrements by 1; value 0 becomes 9 and borrows.
  - sec_tens: value >0 decrements by 1; value 0 becomes 5 and borrows.
  - min_ones: value >0 decrements by 1; value 0 becomes 9 and borrows.
  - min_tens: decrements by 1.
  - A borrow out of min_tens is unreachable.
- Expiry: when a decrement produces 00:00, in the same edge:
  - state goes to DONE, running 0, expired 1;
  - alarm is 1 for exactly the next cycle;
  - prescaler 0.
- DONE holds 00:00 and expired=1 until clr or load.
- Maximum preset is 99:59, which runs for 5999 ticks.
- Outputs are all registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package countdown_pkg contains:
  - state enum: IDLE, RUN, PAUSE, DONE;
  - constants SEC_TENS_MAX=5 and DIGIT_MAX=9;
  - a BCD digit typedef (4 bits).
- Sub-module bcd_digit_down: one digit with parameter MAX.
  - Inputs: dec_en, load_en, load_val.
  - Outputs: digit, borrow_out, which is asserted when dec_en is high and the digit is 0.
  - Four instances chained borrow_out to the next dec_en.
- The top level holds the FSM, the prescaler and the saturation logic.

Test Plan:
- TICK_COUNT=4, reset_n low for 2 cycles -> all digits 0, running/expired/alarm 0. Then start_stop -> stays IDLE, running 0.
- Load 00:03, then start_stop -> running 1. Digits read 00:02, 00:01, 00:00 at cycles 4, 8 and 12 after the start edge. alarm high for exactly 1 cycle after 00:00, expired 1, running 0. A further start_stop is ignored.
- Load 10:00, run 1 tick -> 09:59. Load 01:00 -> after 1 tick 00:59, borrow chain verified.
- Load 00:05, start, wait 2 cycles, start_stop (pause), idle 20 cycles -> digits stay 00:05. Resume -> 00:04 appears 2 cycles after resume.
- Load preset with pre_sec_tens=7 and pre_min_ones=12 -> digits saturate to 5 and 9. Assert clr and load together -> digits 00:00, IDLE.
- Running at 00:02, pulse reset_n low for 1 cycle -> all outputs at reset values on the next cycle. A start_stop coincident with a tick -> PAUSE, no decrement.
